// File: rtl/tdm_codec_serdes.sv
// TDM codec serial engine: BICK/frame clock generation, DAC shift-out, ADC capture, PDN release.
// Optional macro TDM_LOOPBACK_EN adds i_loopback, feeding the internal sdin back into the RX path.
module tdm_codec_serdes #(
    parameter int unsigned W          = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned N_CHANNELS = 4,
    parameter int unsigned BICK_DIV   = 1,
    parameter int unsigned DELAY1     = 0,
    parameter int unsigned FS_PULSE   = 0,
    parameter int unsigned PDN_FRAMES = 20000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
`ifdef TDM_LOOPBACK_EN
    input  logic                    i_loopback,
`endif
    input  logic                    i_sdout,
    input  logic [N_CHANNELS*W-1:0] i_sample_in,
    output logic                    o_bick,
    output logic                    o_lrck,
    output logic                    o_sdin,
    output logic                    o_pdn,
    output logic                    o_frame_strobe,
    output logic [N_CHANNELS*W-1:0] o_sample_out
);
    localparam int unsigned DIV_W   = (BICK_DIV > 1) ? $clog2(BICK_DIV) : 1;
    localparam int unsigned BIT_W   = $clog2(SLOT_W);
    localparam int unsigned SLOT_IW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int unsigned IDX_W   = $clog2(W);
    localparam int unsigned PDN_W   = (PDN_FRAMES > 0) ? $clog2(PDN_FRAMES + 1) : 1;

    logic [DIV_W-1:0]             r_div;
    logic                         r_bick;
    logic                         r_lrck;
    logic                         r_sdin;
    logic                         r_strobe;
    logic                         r_pdn;
    logic [BIT_W-1:0]             r_bit_cnt;
    logic [SLOT_IW-1:0]           r_slot;
    logic [1:0]                   r_sync;
    logic [N_CHANNELS-1:0][W-1:0] r_tx;
    logic [N_CHANNELS-1:0][W-1:0] r_rx;
    logic [N_CHANNELS-1:0][W-1:0] r_sample_out;
    logic [PDN_W-1:0]             r_pdn_cnt;

    logic                         w_tick;
    logic                         w_rise;
    logic                         w_fall;
    logic                         w_bit_wrap;
    logic                         w_slot_wrap;
    logic                         w_frame;
    logic [BIT_W-1:0]             w_bit_nxt;
    logic [SLOT_IW-1:0]           w_slot_nxt;
    logic [N_CHANNELS-1:0][W-1:0] w_tx_src;
    logic [31:0]                  w_tx_pos;
    logic [31:0]                  w_rx_pos;
    logic                         w_tx_bit;
    logic                         w_lrck_nxt;
    logic                         w_rx_bit;
    logic                         w_rx_valid;
    logic [IDX_W-1:0]             w_rx_idx;

    always_comb begin
        w_tick      = (r_div == DIV_W'(BICK_DIV - 1));
        w_rise      = w_tick & ~r_bick;
        w_fall      = w_tick & r_bick;
        w_bit_wrap  = (r_bit_cnt == BIT_W'(SLOT_W - 1));
        w_slot_wrap = (r_slot == SLOT_IW'(N_CHANNELS - 1));
        w_frame     = w_fall & w_bit_wrap & w_slot_wrap;
        w_bit_nxt   = w_bit_wrap ? '0 : r_bit_cnt + 1'b1;
        w_slot_nxt  = r_slot;
        if (w_bit_wrap) begin
            w_slot_nxt = w_slot_wrap ? '0 : r_slot + 1'b1;
        end

        // The first bit of a frame must come from the word being latched in the same cycle.
        w_tx_src = w_frame ? i_sample_in : r_tx;
        w_tx_pos = 32'(w_bit_nxt) - DELAY1;
        w_tx_bit = 1'b0;
        if (w_tx_pos < W) begin
            w_tx_bit = w_tx_src[w_slot_nxt][IDX_W'(W - 1 - w_tx_pos)];
        end

        if (FS_PULSE != 0) begin
            w_lrck_nxt = (w_slot_nxt == '0) && (w_bit_nxt == '0);
        end else begin
            w_lrck_nxt = 32'(w_slot_nxt) < (N_CHANNELS / 2);
        end

`ifdef TDM_LOOPBACK_EN
        w_rx_bit = i_loopback ? r_sdin : r_sync[1];
`else
        w_rx_bit = r_sync[1];
`endif
        // Unsigned wrap makes positions before DELAY1 fall out of range.
        w_rx_pos   = 32'(r_bit_cnt) - DELAY1;
        w_rx_valid = (w_rx_pos < W);
        w_rx_idx   = IDX_W'(W - 1 - w_rx_pos);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div        <= '0;
            r_bick       <= 1'b0;
            r_lrck       <= 1'b0;
            r_sdin       <= 1'b0;
            r_strobe     <= 1'b0;
            r_pdn        <= 1'b0;
            r_bit_cnt    <= BIT_W'(SLOT_W - 1);
            r_slot       <= SLOT_IW'(N_CHANNELS - 1);
            r_sync       <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_sample_out <= '0;
            r_pdn_cnt    <= PDN_W'(PDN_FRAMES);
        end else begin
            r_sync   <= {r_sync[0], i_sdout};
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            r_strobe <= w_frame;
            r_pdn    <= (r_pdn_cnt == '0);
            if (w_tick) begin
                r_bick <= ~r_bick;
            end
            if (w_rise && w_rx_valid) begin
                r_rx[r_slot][w_rx_idx] <= w_rx_bit;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_slot    <= w_slot_nxt;
                r_sdin    <= w_tx_bit;
                r_lrck    <= w_lrck_nxt;
            end
            if (w_frame) begin
                r_tx         <= i_sample_in;
                r_sample_out <= r_rx;
                r_rx         <= '0;
                if (r_pdn_cnt != '0) begin
                    r_pdn_cnt <= r_pdn_cnt - 1'b1;
                end
            end
        end
    end

    assign o_bick         = r_bick;
    assign o_lrck         = r_lrck;
    assign o_sdin         = r_sdin;
    assign o_pdn          = r_pdn;
    assign o_frame_strobe = r_strobe;
    assign o_sample_out   = r_sample_out;

endmodule
